// File: rtl/register_sync.sv
// Per-bit resynchronizer for quasi-static signals entering the clk domain.
// Each bit passes through resync_stages flops; reg_o is the last stage.
module register_sync #(
  parameter int                   reg_width     = 1,
  parameter logic [reg_width-1:0] reg_preset    = {reg_width{1'b0}},
  parameter int                   resync_stages = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clk_en,
  input  logic [reg_width-1:0] reg_i,
  output logic [reg_width-1:0] reg_o
);

  if (resync_stages < 2 || resync_stages > 4) begin : g_bad_stages
    $error("register_sync: resync_stages must be in 2..4");
  end
  if (reg_width < 1) begin : g_bad_width
    $error("register_sync: reg_width must be at least 1");
  end

  // Declaration initializer gives the power-up value for instances with nrst tied high.
  (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name AUTO_SHIFT_REGISTER_RECOGNITION OFF", preserve *)
  logic [reg_width-1:0] stage_q [resync_stages] = '{default: reg_preset};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < resync_stages; k++) begin
        stage_q[k] <= reg_preset;
      end
    end else if (clk_en) begin
      stage_q[0] <= reg_i;
      for (int k = 1; k < resync_stages; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign reg_o = stage_q[resync_stages-1];

endmodule

// File: tb/tb_register_sync.sv
// Directed bench for register_sync: power-up preset, latency for 2 and 3
// stages, clock enable, reset priority, bit independence and short pulses.
module tb_register_sync;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: 4 bits, preset 1010, nrst tied high
  logic       nrst_a = 1'b1;
  logic       en_a = 1'b1;
  logic [3:0] reg_i_a = 4'b0000;
  logic [3:0] reg_o_a;

  // dut_b / dut_c: 8 bits, preset 0, 2 and 3 stages sharing stimulus
  logic       nrst_b = 1'b1;
  logic       en_b = 1'b1;
  logic [7:0] reg_i_b = 8'h00;
  logic [7:0] reg_o_b;
  logic [7:0] reg_o_c;

  // dut_d: 2 bits, preset 0
  logic       nrst_d = 1'b1;
  logic       en_d = 1'b1;
  logic [1:0] reg_i_d = 2'b10;
  logic [1:0] reg_o_d;

  int n_checks = 0;
  int n_err = 0;

  register_sync #(.reg_width(4), .reg_preset(4'b1010), .resync_stages(2)) dut_a (
    .clk(clk), .nrst(nrst_a), .clk_en(en_a), .reg_i(reg_i_a), .reg_o(reg_o_a));
  register_sync #(.reg_width(8), .reg_preset(8'h00), .resync_stages(2)) dut_b (
    .clk(clk), .nrst(nrst_b), .clk_en(en_b), .reg_i(reg_i_b), .reg_o(reg_o_b));
  register_sync #(.reg_width(8), .reg_preset(8'h00), .resync_stages(3)) dut_c (
    .clk(clk), .nrst(nrst_b), .clk_en(en_b), .reg_i(reg_i_b), .reg_o(reg_o_c));
  register_sync #(.reg_width(2), .reg_preset(2'b00), .resync_stages(2)) dut_d (
    .clk(clk), .nrst(nrst_d), .clk_en(en_d), .reg_i(reg_i_d), .reg_o(reg_o_d));

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic hist [16];

  initial begin
    // power-up before any edge, nrst tied high
    #1;
    chk_val("pwrup_a_t0", 32'(reg_o_a), 32'h0000000a);
    chk_val("pwrup_d_t0", 32'(reg_o_d), 32'h00000000);
    tick();
    chk_val("pwrup_a_e1", 32'(reg_o_a), 32'h0000000a);
    tick();
    chk_val("pwrup_a_e2", 32'(reg_o_a), 32'h00000000);

    // reset b/c once, then settle at zero
    nrst_b = 1'b0;
    tick();
    nrst_b = 1'b1;
    tick(); tick(); tick();
    chk_val("settle_b", 32'(reg_o_b), 32'h00);
    chk_val("settle_c", 32'(reg_o_c), 32'h00);

    // latency: step to A5, sampled at edge t
    reg_i_b = 8'hA5;
    tick();
    chk_val("lat_b_t", 32'(reg_o_b), 32'h00);
    chk_val("lat_c_t", 32'(reg_o_c), 32'h00);
    tick();
    chk_val("lat_b_t1", 32'(reg_o_b), 32'hA5);
    chk_val("lat_c_t1", 32'(reg_o_c), 32'h00);
    tick();
    chk_val("lat_c_t2", 32'(reg_o_c), 32'hA5);

    // clock enable hold
    reg_i_b = 8'h00;
    tick(); tick(); tick();
    chk_val("en_pre_b", 32'(reg_o_b), 32'h00);
    chk_val("en_pre_c", 32'(reg_o_c), 32'h00);
    en_b = 1'b0;
    reg_i_b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_val("en_hold_b", 32'(reg_o_b), 32'h00);
    end
    chk_val("en_hold_c", 32'(reg_o_c), 32'h00);
    en_b = 1'b1;
    tick();
    chk_val("en_re1_b", 32'(reg_o_b), 32'h00);
    tick();
    chk_val("en_re2_b", 32'(reg_o_b), 32'hFF);
    chk_val("en_re2_c", 32'(reg_o_c), 32'h00);
    tick();
    chk_val("en_re3_c", 32'(reg_o_c), 32'hFF);

    // reset wins over clk_en=0
    en_b = 1'b0;
    nrst_b = 1'b0;
    tick();
    chk_val("rst_b", 32'(reg_o_b), 32'h00);
    chk_val("rst_c", 32'(reg_o_c), 32'h00);
    nrst_b = 1'b1;
    en_b = 1'b1;
    tick();
    chk_val("rel1_b", 32'(reg_o_b), 32'h00);
    tick();
    chk_val("rel2_b", 32'(reg_o_b), 32'hFF);
    chk_val("rel2_c", 32'(reg_o_c), 32'h00);
    tick();
    chk_val("rel3_c", 32'(reg_o_c), 32'hFF);

    // bit independence: bit0 toggles every 4 cycles, bit1 held at 1
    for (int i = 0; i < 16; i++) begin
      hist[i] = ((i / 4) % 2) == 1;
      reg_i_d = {1'b1, hist[i]};
      tick();
      if (i >= 1) begin
        chk_val("tog_d", 32'(reg_o_d), {30'd0, 1'b1, hist[i-1]});
      end
    end
    reg_i_d = 2'b10;
    tick(); tick();
    chk_val("tog_idle_d", 32'(reg_o_d), 32'h2);

    // glitch fully between edges is missed
    #2 reg_i_d = 2'b11;
    #4 reg_i_d = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_val("glitch_miss_d", 32'(reg_o_d), 32'h2);
    end

    // pulse spanning one edge is captured for exactly one cycle
    #4 reg_i_d = 2'b11;
    tick();
    reg_i_d = 2'b10;
    tick();
    chk_val("pulse_cap_d", 32'(reg_o_d), 32'h3);
    tick();
    chk_val("pulse_end_d", 32'(reg_o_d), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
